alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU: one-shot square-modulus or a multi-generation 1-D cellular automaton,
// behind a valid/ready command port and a valid/ready response port.
module alu_seq_ctrl #(
  parameter int unsigned GEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [GEN_W-1:0] cmd_gens,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_y,
  output logic             rsp_err,
  output logic             busy,
  output logic [GEN_W-1:0] gen_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic             op_q, op_n;
  logic [DW-1:0]    a_q, a_n;
  logic [BW-1:0]    b_q, b_n;
  logic [GEN_W-1:0] gens_q, gens_n;
  logic             phase_q, phase_n;
  logic             cmd_ready_n, rsp_valid_n, busy_n, rsp_err_n;
  logic [DW-1:0]    rsp_y_n;
  logic [GEN_W-1:0] gen_cnt_n;
  logic [DW-1:0]    sq_c, mod_c, ca_c;

  // One CA step: each bit looks up the rule with {right neighbour, self}, ring of 8.
  function automatic logic [DW-1:0] ca_step(input logic [DW-1:0] s, input logic [BW-1:0] rule);
    logic [DW-1:0] y;
    y = '0;
    for (int i = 0; i < DW; i++) begin
      y[i] = rule[{s[3'(i + 1)], s[3'(i)]}];
    end
    return y;
  endfunction

  always_comb begin
    sq_c  = DW'(b_q) * DW'(b_q);
    mod_c = (a_q == '0) ? '0 : (sq_c % a_q);
    ca_c  = ca_step(a_q, b_q);
  end

  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    a_n       = a_q;
    b_n       = b_q;
    gens_n    = gens_q;
    phase_n   = phase_q;
    rsp_y_n   = rsp_y;
    rsp_err_n = rsp_err;
    gen_cnt_n = gen_cnt;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n      = cmd_op;
          a_n       = cmd_a;
          b_n       = cmd_b;
          gens_n    = cmd_gens;
          gen_cnt_n = '0;
          phase_n   = 1'b0;
          rsp_err_n = 1'b0;
          // A zero-generation CA run passes through RUN too, so its result lands one edge after accept.
          state_n   = RUN;
        end
      end
      RUN: begin
        if (!op_q) begin
          if (!phase_q) begin
            rsp_y_n   = mod_c;
            rsp_err_n = (a_q == '0);
            phase_n   = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else if (gen_cnt == gens_q) begin
          rsp_y_n   = a_q;
          rsp_err_n = 1'b0;
          state_n   = DONE;
        end else begin
          a_n       = ca_c;
          gen_cnt_n = gen_cnt + GEN_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
    rsp_valid_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      gens_q    <= '0;
      phase_q   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
      gen_cnt   <= '0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      a_q       <= a_n;
      b_q       <= b_n;
      gens_q    <= gens_n;
      phase_q   <= phase_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      busy      <= busy_n;
      rsp_y     <= rsp_y_n;
      rsp_err   <= rsp_err_n;
      gen_cnt   <= gen_cnt_n;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl.
module tb_alu_seq_ctrl;

  localparam int unsigned GEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [7:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [GEN_W-1:0] cmd_gens;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_y;
  logic             rsp_err;
  logic             busy;
  logic [GEN_W-1:0] gen_cnt;

  int total = 0;
  int bad   = 0;

  alu_seq_ctrl #(.GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_gens(cmd_gens),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_err(rsp_err), .busy(busy), .gen_cnt(gen_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command, clocks the accept edge and drops cmd_valid.
  task automatic send(input logic op, input logic [7:0] a, input logic [3:0] b, input logic [GEN_W-1:0] g);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_gens = g; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Edges after the accept edge until rsp_valid, bounded at 100.
  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (rsp_y !== 8'h00) begin bad++; $display("FAIL rst_rsp_y got=%h exp=00", rsp_y); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    total++; if (gen_cnt !== 4'd0) begin bad++; $display("FAIL rst_gen_cnt got=%0d exp=0", gen_cnt); end
    rst = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_mod();
    int n;
    rsp_ready = 1'b1;
    send(1'b0, 8'd7, 4'd9, 4'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mod_busy got=%b exp=1", busy); end
    wait_valid(n);
    total++; if (n !== 2) begin bad++; $display("FAIL mod_latency got=%0d exp=2", n); end
    total++; if (rsp_y !== 8'h04) begin bad++; $display("FAIL mod_y got=%h exp=04", rsp_y); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL mod_err got=%b exp=0", rsp_err); end
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mod_ready_after got=%b exp=1", cmd_ready); end
    send(1'b0, 8'd200, 4'd15, 4'd0);
    wait_valid(n);
    total++; if (n !== 2) begin bad++; $display("FAIL mod200_latency got=%0d exp=2", n); end
    total++; if (rsp_y !== 8'h19) begin bad++; $display("FAIL mod200_y got=%h exp=19", rsp_y); end
    tick();
    send(1'b0, 8'd0, 4'd5, 4'd0);
    wait_valid(n);
    total++; if (n !== 2) begin bad++; $display("FAIL modzero_latency got=%0d exp=2", n); end
    total++; if (rsp_y !== 8'h00) begin bad++; $display("FAIL modzero_y got=%h exp=00", rsp_y); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL modzero_err got=%b exp=1", rsp_err); end
    tick();
  endtask

  task automatic test_ca();
    logic [7:0] exp_st [1:3];
    exp_st[1] = 8'h81; exp_st[2] = 8'h41; exp_st[3] = 8'hE1;
    rsp_ready = 1'b1;
    send(1'b1, 8'h01, 4'b0110, 4'd3);
    total++; if (gen_cnt !== 4'd0) begin bad++; $display("FAIL ca_cnt0 got=%0d exp=0", gen_cnt); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (gen_cnt !== 4'(k)) begin bad++; $display("FAIL ca_cnt gen=%0d got=%0d exp=%0d", k, gen_cnt, k); end
      total++; if (dut.a_q !== exp_st[k]) begin bad++; $display("FAIL ca_state gen=%0d got=%h exp=%h", k, dut.a_q, exp_st[k]); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ca_early_valid gen=%0d got=%b exp=0", k, rsp_valid); end
    end
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ca_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_y !== 8'hE1) begin bad++; $display("FAIL ca_y got=%h exp=e1", rsp_y); end
    total++; if (gen_cnt !== 4'd3) begin bad++; $display("FAIL ca_gen_cnt got=%0d exp=3", gen_cnt); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL ca_err got=%b exp=0", rsp_err); end
    tick();
  endtask

  task automatic test_max_gens();
    int n;
    rsp_ready = 1'b1;
    send(1'b1, 8'h01, 4'b1100, 4'd15);
    wait_valid(n);
    total++; if (n !== 16) begin bad++; $display("FAIL max_latency got=%0d exp=16", n); end
    total++; if (rsp_y !== 8'h02) begin bad++; $display("FAIL max_y got=%h exp=02", rsp_y); end
    total++; if (gen_cnt !== 4'd15) begin bad++; $display("FAIL max_gen_cnt got=%0d exp=15", gen_cnt); end
    tick();
  endtask

  task automatic test_zero_gens_hold();
    int n;
    rsp_ready = 1'b0;
    send(1'b1, 8'h5A, 4'b0110, 4'd0);
    wait_valid(n);
    total++; if (n !== 1) begin bad++; $display("FAIL zg_latency got=%0d exp=1", n); end
    for (int k = 0; k < 5; k++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", k, rsp_valid); end
      total++; if (rsp_y !== 8'h5A) begin bad++; $display("FAIL hold_y cyc=%0d got=%h exp=5a", k, rsp_y); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL hold_err cyc=%0d got=%b exp=0", k, rsp_err); end
      total++; if (gen_cnt !== 4'd0) begin bad++; $display("FAIL hold_cnt cyc=%0d got=%0d exp=0", k, gen_cnt); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", k, cmd_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hs_valid got=%b exp=0", rsp_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL hs_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    rsp_ready = 1'b1;
    send(1'b1, 8'h01, 4'b0110, 4'd10);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b exp=0", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mr_ready got=%b exp=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", rsp_valid); end
    total++; if (gen_cnt !== 4'd0) begin bad++; $display("FAIL mr_cnt got=%0d exp=0", gen_cnt); end
    total++; if (rsp_y !== 8'h00) begin bad++; $display("FAIL mr_y got=%h exp=00", rsp_y); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_ready_after got=%b exp=1", cmd_ready); end
    send(1'b0, 8'd10, 4'd12, 4'd0);
    wait_valid(n);
    total++; if (n !== 2) begin bad++; $display("FAIL mr_mod_latency got=%0d exp=2", n); end
    total++; if (rsp_y !== 8'h04) begin bad++; $display("FAIL mr_mod_y got=%h exp=04", rsp_y); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    rsp_ready = 1'b1;
    cmd_op = 1'b0; cmd_a = 8'd11; cmd_b = 4'd7; cmd_gens = 4'd0; cmd_valid = 1'b1;
    tick();
    cmd_a = 8'd3;
    tick();
    cmd_a = 8'd200; cmd_b = 4'd2;
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_y !== 8'h05) begin bad++; $display("FAIL b2b_first_y got=%h exp=05", rsp_y); end
    cmd_a = 8'd13; cmd_b = 4'd6;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_hs_busy got=%b exp=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_hs_ready got=%b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
    wait_valid(n);
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", n); end
    total++; if (rsp_y !== 8'h0A) begin bad++; $display("FAIL b2b_second_y got=%h exp=0a", rsp_y); end
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0;
    cmd_gens = '0; rsp_ready = 1'b0;
    test_reset();
    test_mod();
    test_ca();
    test_max_gens();
    test_zero_gens_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
